mul_arbiter: RTL and testbench

MUL_ARBITER -- requirements
Module: mul_arbiter

---
 rtl/mul_arbiter_pkg.sv | 19 +
 rtl/mul_arbiter_if.sv | 39 +++
 rtl/mul_arbiter_tag_pipe.sv | 36 +++
 rtl/mul_arbiter.sv | 118 +++++++++++
 tb/tb_mul_arbiter.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mul_arbiter_pkg.sv
// Shared types and widths for the round-robin multiplier arbiter.
// Tags carry {valid, requester id} alongside each in-flight multiply.
package mul_arb_pkg;

    localparam int TAG_ID_W = 3;
    localparam int CNT_W = 4;

    typedef struct packed {
        logic                vld;
        logic [TAG_ID_W-1:0] id;
    } tag_t;

    localparam int TAG_W = $bits(tag_t);

    function automatic int id_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mul_arbiter_if.sv
// Requester, response and multiplier-side signals of the arbiter.
// slave is the arbiter's view, master is the environment's view.
interface mul_arbiter_if #(
    parameter int N_REQ = 2
);

    logic [N_REQ-1:0]       req_vld;
    logic [N_REQ-1:0]       req_rdy;
    logic [N_REQ-1:0][31:0] req_a;
    logic [N_REQ-1:0][31:0] req_b;
    logic [N_REQ-1:0]       rsp_vld;
    logic [31:0]            rsp_data;
    logic                   clear;
    logic [31:0]            mul_srcA;
    logic [31:0]            mul_srcB;
    logic                   mul_src_vld;
    logic                   mul_clear;
    logic [31:0]            mul_res;
    logic                   mul_res_vld;
    logic                   busy;
    logic                   err;

    modport slave (
        input  req_vld, req_a, req_b, clear,
        input  mul_res, mul_res_vld,
        output req_rdy, rsp_vld, rsp_data,
        output mul_srcA, mul_srcB, mul_src_vld, mul_clear,
        output busy, err
    );

    modport master (
        output req_vld, req_a, req_b, clear,
        output mul_res, mul_res_vld,
        input  req_rdy, rsp_vld, rsp_data,
        input  mul_srcA, mul_srcB, mul_src_vld, mul_clear,
        input  busy, err
    );

endinterface

// File: rtl/mul_arbiter_tag_pipe.sv
// Fixed-latency tag shift register; the tag leaves in the cycle the
// matching multiplier result is due.
module mul_tag_pipe #(
    parameter int LATENCY = 2,
    parameter int TAG_W   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic [TAG_W-1:0] in,
    output logic [TAG_W-1:0] out
);

    logic [LATENCY-1:0][TAG_W-1:0] pipe_q;
    logic [LATENCY-1:0][TAG_W-1:0] pipe_d;

    always_comb begin
        pipe_d = pipe_q;
        if (clear) begin
            pipe_d = '0;
        end else begin
            pipe_d[0] = in;
            for (int i = 1; i < LATENCY; i++) begin
                pipe_d[i] = pipe_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) pipe_q <= '0;
        else       pipe_q <= pipe_d;
    end

    assign out = pipe_q[LATENCY-1];

endmodule

// File: rtl/mul_arbiter.sv
// Round-robin arbiter sharing one pipelined multiplier among N_REQ
// requesters, with per-requester credit limits and result routing.
module mul_arbiter
    import mul_arb_pkg::*;
#(
    parameter int N_REQ   = 2,
    parameter int LATENCY = 2,
    parameter int MAX_OUT = 4
) (
    input logic           clk,
    input logic           reset,
    mul_arbiter_if.slave  bus
);

    localparam int ID_W  = id_width(N_REQ);
    localparam int OCC_W = $clog2(LATENCY + 2);

    logic [ID_W-1:0]             last_q, last_d;
    logic [N_REQ-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [OCC_W-1:0]            occ_q, occ_d;
    logic                        err_q, err_d;

    logic [N_REQ-1:0] elig;
    logic [N_REQ-1:0] gnt;
    logic [N_REQ-1:0] rsp;
    logic [ID_W-1:0]  gnt_id;
    logic             gnt_any;
    logic             hit;
    int               rr_idx;
    tag_t             tag_in;
    tag_t             tag_out;

    // Search starts one past the previous winner so every requester rotates.
    always_comb begin
        elig    = '0;
        gnt     = '0;
        gnt_id  = '0;
        gnt_any = 1'b0;
        rr_idx  = 0;
        for (int i = 0; i < N_REQ; i++) begin
            elig[i] = bus.req_vld[i] && (cnt_q[i] < CNT_W'(MAX_OUT))
                      && !bus.clear && !reset;
        end
        for (int k = 1; k <= N_REQ; k++) begin
            rr_idx = (int'(last_q) + k) % N_REQ;
            if (!gnt_any && elig[ID_W'(rr_idx)]) begin
                gnt_any = 1'b1;
                gnt_id  = ID_W'(rr_idx);
            end
        end
        if (gnt_any) gnt[gnt_id] = 1'b1;
    end

    always_comb begin
        tag_in     = '0;
        tag_in.vld = gnt_any;
        tag_in.id  = TAG_ID_W'(gnt_id);
    end

    mul_tag_pipe #(
        .LATENCY (LATENCY),
        .TAG_W   (TAG_W)
    ) u_tag_pipe (
        .clk   (clk),
        .reset (reset),
        .clear (bus.clear),
        .in    (tag_in),
        .out   (tag_out)
    );

    always_comb begin
        rsp = '0;
        hit = tag_out.vld && bus.mul_res_vld && !bus.clear && !reset;
        for (int i = 0; i < N_REQ; i++) begin
            rsp[i] = hit && (tag_out.id == TAG_ID_W'(i));
        end
    end

    always_comb begin
        last_d = gnt_any ? gnt_id : last_q;
        err_d  = err_q | (!bus.clear & (bus.mul_res_vld ^ tag_out.vld));
        occ_d  = occ_q + OCC_W'(tag_in.vld) - OCC_W'(tag_out.vld);
        cnt_d  = cnt_q;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i] && !rsp[i])      cnt_d[i] = cnt_q[i] + CNT_W'(1);
            else if (!gnt[i] && rsp[i]) cnt_d[i] = cnt_q[i] - CNT_W'(1);
        end
        if (bus.clear) begin
            occ_d = '0;
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q <= ID_W'(N_REQ - 1);
            cnt_q  <= '0;
            occ_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            last_q <= last_d;
            cnt_q  <= cnt_d;
            occ_q  <= occ_d;
            err_q  <= err_d;
        end
    end

    assign bus.req_rdy     = gnt;
    assign bus.mul_src_vld = gnt_any;
    assign bus.mul_srcA    = bus.req_a[gnt_id];
    assign bus.mul_srcB    = bus.req_b[gnt_id];
    assign bus.mul_clear   = bus.clear;
    assign bus.rsp_vld     = rsp;
    assign bus.rsp_data    = bus.mul_res;
    assign bus.busy        = (occ_q != '0);
    assign bus.err         = err_q;

endmodule

// File: tb/tb_mul_arbiter.sv
// Bench for mul_arbiter: transaction-level reference model with
// fixed-latency multiplier models, directed and random traffic.
module tb_mul_arbiter;

    localparam int N    = 2;
    localparam int LAT  = 2;
    localparam int LAT2 = 6;
    localparam int MAXO = 4;

    logic clk = 1'b0;
    logic reset;
    logic inj;

    always #5 clk = ~clk;

    mul_arbiter_if #(.N_REQ(N)) b1 ();
    mul_arbiter_if #(.N_REQ(N)) b2 ();

    mul_arbiter #(.N_REQ(N), .LATENCY(LAT), .MAX_OUT(MAXO)) u1 (
        .clk   (clk),
        .reset (reset),
        .bus   (b1)
    );

    mul_arbiter #(.N_REQ(N), .LATENCY(LAT2), .MAX_OUT(MAXO)) u2 (
        .clk   (clk),
        .reset (reset),
        .bus   (b2)
    );

    // Fixed-latency multipliers attached to each arbiter.
    logic [LAT-1:0]         mv1;
    logic [LAT-1:0][31:0]   md1;
    logic [LAT2-1:0]        mv2;
    logic [LAT2-1:0][31:0]  md2;

    always @(posedge clk or posedge reset) begin
        if (reset || b1.mul_clear) mv1 <= '0;
        else mv1 <= {mv1[LAT-2:0], b1.mul_src_vld};
        md1 <= {md1[LAT-2:0], b1.mul_srcA * b1.mul_srcB};
        if (reset || b2.mul_clear) mv2 <= '0;
        else mv2 <= {mv2[LAT2-2:0], b2.mul_src_vld};
        md2 <= {md2[LAT2-2:0], b2.mul_srcA * b2.mul_srcB};
    end

    assign b1.mul_res_vld = mv1[LAT-1] | inj;
    assign b1.mul_res     = md1[LAT-1];
    assign b2.mul_res_vld = mv2[LAT2-1];
    assign b2.mul_res     = md2[LAT2-1];

    typedef struct {
        int          due;
        int          id;
        logic [31:0] data;
    } pend_t;

    pend_t pq[$];
    int    outs[N];
    int    last_m;
    int    cyc;
    int    n_chk;
    int    n_pass;
    logic  err_m;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                      tag, got, exp, cyc);
    endtask

    function automatic logic [31:0] prod(input logic [31:0] a,
                                         input logic [31:0] b);
        logic [63:0] p;
        p = {32'd0, a} * {32'd0, b};
        return p[31:0];
    endfunction

    task automatic model_reset();
        pq.delete();
        outs   = '{default: 0};
        last_m = N - 1;
        err_m  = 1'b0;
    endtask

    task automatic drive(input logic [N-1:0] v, input logic clr,
                         input logic [31:0] a0, input logic [31:0] bb0,
                         input logic [31:0] a1, input logic [31:0] bb1);
        b1.req_vld  = v;
        b1.clear    = clr;
        b1.req_a[0] = a0;
        b1.req_b[0] = bb0;
        b1.req_a[1] = a1;
        b1.req_b[1] = bb1;
    endtask

    // One cycle of u1: predict, compare at negedge, then advance the model.
    task automatic step();
        int           w;
        int           hit;
        logic [N-1:0] erdy;
        logic [N-1:0] ersp;
        @(negedge clk);
        w = -1;
        for (int k = 1; k <= N; k++) begin
            int j;
            j = (last_m + k) % N;
            if (w < 0 && b1.req_vld[j] && outs[j] < MAXO && !b1.clear) w = j;
        end
        erdy = '0;
        if (w >= 0) erdy[w] = 1'b1;
        hit = -1;
        foreach (pq[q]) if (pq[q].due == cyc) hit = q;
        ersp = '0;
        if (hit >= 0 && !b1.clear) ersp[pq[hit].id] = 1'b1;
        chk("req_rdy", b1.req_rdy, erdy);
        chk("mul_src_vld", b1.mul_src_vld, w >= 0);
        if (w >= 0) begin
            chk("mul_srcA", b1.mul_srcA, b1.req_a[w]);
            chk("mul_srcB", b1.mul_srcB, b1.req_b[w]);
        end
        chk("mul_clear", b1.mul_clear, b1.clear);
        chk("rsp_vld", b1.rsp_vld, ersp);
        if (ersp != '0) chk("rsp_data", b1.rsp_data, pq[hit].data);
        chk("busy", b1.busy, pq.size() != 0);
        chk("err", b1.err, err_m);
        if (b1.clear) begin
            pq.delete();
            outs = '{default: 0};
        end else begin
            if (hit >= 0) begin
                outs[pq[hit].id]--;
                pq.delete(hit);
            end else if (inj) begin
                err_m = 1'b1;
            end
            if (w >= 0) begin
                pq.push_back('{cyc + LAT, w,
                               prod(b1.req_a[w], b1.req_b[w])});
                outs[w]++;
                last_m = w;
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    int acc_t[$];
    int acc_n;
    int o;
    logic rdy_e;
    logic rsp_e;

    initial begin
        n_chk  = 0;
        n_pass = 0;
        cyc    = 0;
        inj    = 1'b0;
        reset  = 1'b1;
        model_reset();
        drive(2'b11, 1'b0, 32'd3, 32'd5, 32'd7, 32'd9);
        b2.req_vld = '0;
        b2.req_a   = '0;
        b2.req_b   = '0;
        b2.clear   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rdy", b1.req_rdy, 0);
        chk("rst_src_vld", b1.mul_src_vld, 0);
        chk("rst_busy", b1.busy, 0);
        chk("rst_err", b1.err, 0);
        reset = 1'b0;

        // Alternating grants, 3x5 and 7x9.
        repeat (8) step();

        // All-ones operand times two.
        drive(2'b01, 1'b0, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0);
        repeat (4) step();

        // Flush with two operations in flight.
        drive(2'b11, 1'b0, 32'd11, 32'd13, 32'd17, 32'd19);
        repeat (2) step();
        drive(2'b11, 1'b1, 32'd11, 32'd13, 32'd17, 32'd19);
        step();
        drive(2'b11, 1'b0, 32'd21, 32'd23, 32'd25, 32'd27);
        repeat (4) step();

        for (int r = 0; r < 300; r++) begin
            drive(N'($urandom), ($urandom_range(19) == 0),
                  $urandom, $urandom, $urandom, $urandom);
            step();
        end

        // Spurious multiplier result with nothing in flight.
        drive(2'b00, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
        repeat (4) step();
        inj = 1'b1;
        step();
        inj = 1'b0;
        drive(2'b11, 1'b0, 32'd4, 32'd6, 32'd8, 32'd10);
        repeat (5) step();

        // Asynchronous reset in the middle of traffic.
        #2;
        reset = 1'b1;
        #1;
        chk("arst_rdy", b1.req_rdy, 0);
        chk("arst_src_vld", b1.mul_src_vld, 0);
        chk("arst_rsp_vld", b1.rsp_vld, 0);
        chk("arst_busy", b1.busy, 0);
        chk("arst_err", b1.err, 0);
        b1.clear = 1'b1;
        #1;
        chk("arst_mul_clear", b1.mul_clear, 1);
        b1.clear = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (6) step();

        // Credit limit on a long-latency multiplier.
        b2.req_vld = 2'b01;
        b2.req_a   = {32'd0, 32'd6};
        b2.req_b   = {32'd0, 32'd7};
        acc_n = 0;
        for (int t = 0; t < 16; t++) begin
            @(negedge clk);
            o     = 0;
            rsp_e = 1'b0;
            foreach (acc_t[k]) begin
                if (acc_t[k] + LAT2 >= t) o++;
                if (acc_t[k] + LAT2 == t) rsp_e = 1'b1;
            end
            rdy_e = (o < MAXO);
            chk("u2_rdy", b2.req_rdy, {1'b0, rdy_e});
            chk("u2_rsp", b2.rsp_vld, {1'b0, rsp_e});
            if (rsp_e) chk("u2_data", b2.rsp_data, 42);
            if (t < LAT2 && b2.req_rdy[0]) acc_n++;
            if (rdy_e) acc_t.push_back(t);
            @(posedge clk);
            #1;
        end
        chk("u2_accepts", acc_n, MAXO);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
